// File: rtl/updown_datapath.sv
// Bounded up/down count register executing clear/load commands from the counter controller.
// Define UPDOWN_WRAP_EN for modular counting instead of saturate-and-flag behaviour.
module updown_datapath #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MIN_VAL = 0,
   parameter int unsigned MAX_VAL = 9,
   parameter int unsigned STEP    = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op,
   input  logic             c_clr,
   input  logic             c_ld,
   output logic             z,
   output logic             m,
   output logic [WIDTH-1:0] count,
   output logic             upd,
   output logic             err_ovf,
   output logic             err_udf,
   output logic [15:0]      ld_total
);

   // One extra bit so bound checks and step arithmetic never wrap silently.
   localparam logic [WIDTH:0] MinW  = (WIDTH+1)'(MIN_VAL);
   localparam logic [WIDTH:0] MaxW  = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0] StepW = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0] LoLim = MinW + StepW;
   localparam logic [WIDTH:0] HiLim = MaxW - StepW;

   logic [WIDTH-1:0] count_q, count_d;
   logic             upd_q, upd_d;
   logic             err_ovf_q, err_ovf_d;
   logic             err_udf_q, err_udf_d;
   logic [15:0]      ld_total_q, ld_total_d;

   logic [WIDTH:0]   cnt_ext;
   logic             can_inc, can_dec, accept;

   assign cnt_ext = {1'b0, count_q};
   assign can_dec = (cnt_ext >= LoLim);
   assign can_inc = (cnt_ext <= HiLim);

   always_comb begin
      count_d    = count_q;
      upd_d      = 1'b0;
      err_ovf_d  = err_ovf_q;
      err_udf_d  = err_udf_q;
      ld_total_d = ld_total_q;
      accept     = 1'b0;

      if (c_clr) begin
         count_d    = MinW[WIDTH-1:0];
         err_ovf_d  = 1'b0;
         err_udf_d  = 1'b0;
         ld_total_d = 16'd0;
      end else if (c_ld) begin
         if (!op) begin
            if (can_inc) begin
               count_d = WIDTH'(cnt_ext + StepW);
               accept  = 1'b1;
            end else begin
`ifdef UPDOWN_WRAP_EN
               count_d = MinW[WIDTH-1:0];
               accept  = 1'b1;
`else
               err_ovf_d = 1'b1;
`endif
            end
         end else begin
            if (can_dec) begin
               count_d = WIDTH'(cnt_ext - StepW);
               accept  = 1'b1;
            end else begin
`ifdef UPDOWN_WRAP_EN
               count_d = MaxW[WIDTH-1:0];
               accept  = 1'b1;
`else
               err_udf_d = 1'b1;
`endif
            end
         end

         if (accept) begin
            upd_d = 1'b1;
            if (ld_total_q != 16'hFFFF) begin
               ld_total_d = ld_total_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q    <= MinW[WIDTH-1:0];
         upd_q      <= 1'b0;
         err_ovf_q  <= 1'b0;
         err_udf_q  <= 1'b0;
         ld_total_q <= 16'd0;
      end else begin
         count_q    <= count_d;
         upd_q      <= upd_d;
         err_ovf_q  <= err_ovf_d;
         err_udf_q  <= err_udf_d;
         ld_total_q <= ld_total_d;
      end
   end

`ifdef UPDOWN_WRAP_EN
   assign z = 1'b1;
   assign m = 1'b1;
`else
   assign z = can_dec;
   assign m = can_inc;
`endif

   // In wrap builds the error flops are never set, so the flags stay at 0.
   assign count    = count_q;
   assign upd      = upd_q;
   assign err_ovf  = err_ovf_q;
   assign err_udf  = err_udf_q;
   assign ld_total = ld_total_q;

endmodule

// File: tb/tb_updown_datapath.sv
// Bench for updown_datapath: directed scenarios plus random commands against an arithmetic model.
module tb_updown_datapath;

   localparam int WIDTH   = 4;
   localparam int MIN_VAL = 0;
   localparam int MAX_VAL = 9;
   localparam int STEP    = 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             op, c_clr, c_ld;
   logic             z, m, upd, err_ovf, err_udf;
   logic [WIDTH-1:0] count;
   logic [15:0]      ld_total;

   int total = 0;
   int bad   = 0;

   // Reference state
   int e_cnt, e_tot;
   bit e_upd, e_ovf, e_udf;

   always #5 clk = ~clk;

   updown_datapath #(
      .WIDTH  (WIDTH),
      .MIN_VAL(MIN_VAL),
      .MAX_VAL(MAX_VAL),
      .STEP   (STEP)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .op      (op),
      .c_clr   (c_clr),
      .c_ld    (c_ld),
      .z       (z),
      .m       (m),
      .count   (count),
      .upd     (upd),
      .err_ovf (err_ovf),
      .err_udf (err_udf),
      .ld_total(ld_total)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      e_cnt = MIN_VAL; e_tot = 0; e_upd = 0; e_ovf = 0; e_udf = 0;
   endtask

   task automatic model_accept(input int nv);
      e_cnt = nv;
      e_upd = 1;
      if (e_tot < 65535) e_tot = e_tot + 1;
   endtask

   task automatic model_edge(input bit clr, input bit ld, input bit o);
      e_upd = 0;
      if (clr) begin
         e_cnt = MIN_VAL; e_ovf = 0; e_udf = 0; e_tot = 0;
      end else if (ld) begin
         if (!o) begin
            if (e_cnt + STEP <= MAX_VAL) model_accept(e_cnt + STEP);
`ifdef UPDOWN_WRAP_EN
            else model_accept(MIN_VAL);
`else
            else e_ovf = 1;
`endif
         end else begin
            if (e_cnt - STEP >= MIN_VAL) model_accept(e_cnt - STEP);
`ifdef UPDOWN_WRAP_EN
            else model_accept(MAX_VAL);
`else
            else e_udf = 1;
`endif
         end
      end
   endtask

   task automatic check_all(input string tag);
      bit ez, em;
`ifdef UPDOWN_WRAP_EN
      ez = 1; em = 1;
`else
      ez = (e_cnt >= MIN_VAL + STEP);
      em = (e_cnt <= MAX_VAL - STEP);
`endif
      check({tag, ".count"}, 32'(count), 32'(e_cnt));
      check({tag, ".z"}, 32'(z), 32'(ez));
      check({tag, ".m"}, 32'(m), 32'(em));
      check({tag, ".upd"}, 32'(upd), 32'(e_upd));
      check({tag, ".err_ovf"}, 32'(err_ovf), 32'(e_ovf));
      check({tag, ".err_udf"}, 32'(err_udf), 32'(e_udf));
      check({tag, ".ld_total"}, 32'(ld_total), 32'(e_tot));
   endtask

   // Drive on the falling edge, apply on the rising edge, sample 1 time unit later.
   task automatic cmd(input bit clr, input bit ld, input bit o, input string tag, input bit chk);
      @(negedge clk);
      c_clr = clr; c_ld = ld; op = o;
      @(posedge clk);
      model_edge(clr, ld, o);
      #1;
      if (chk) check_all(tag);
   endtask

   initial begin
      reset = 1'b1; op = 1'b0; c_clr = 1'b0; c_ld = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      reset = 1'b0;

      // Climb to the upper bound, then one step past it.
      for (int i = 0; i < 9; i++) cmd(0, 1, 0, "inc", 1);
      cmd(0, 1, 0, "inc_over", 1);
      cmd(0, 0, 0, "idle_after_over", 1);

      // Underflow from MIN, then recover upward.
      cmd(1, 0, 0, "clr", 1);
      cmd(0, 1, 1, "dec_under", 1);
      cmd(0, 1, 0, "inc_after_under", 1);

      // Reach count=5 with err_ovf set, then clear and load together.
      for (int i = 0; i < 9; i++) cmd(0, 1, 0, "inc2", 1);
      for (int i = 0; i < 4; i++) cmd(0, 1, 1, "dec2", 1);
      cmd(1, 1, 0, "clr_prio", 1);

      // Asynchronous reset between edges at count=7.
      for (int i = 0; i < 7; i++) cmd(0, 1, 0, "inc3", 1);
      @(negedge clk);
      c_ld = 1'b0;
      @(posedge clk);
      model_edge(0, 0, 0);
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      check_all("async_rst");
      @(negedge clk);
      reset = 1'b0;
      cmd(0, 1, 0, "post_rst_inc", 1);

      // Random command mix.
      for (int i = 0; i < 400; i++) begin
         cmd(($urandom_range(15) == 0), ($urandom_range(3) != 0), 1'($urandom_range(1)),
             "rand", 1);
      end

      // Saturate the step counter with accepted steps alternating up and down.
      cmd(1, 0, 0, "sat_clr", 1);
      for (int i = 0; i < 65540; i++) cmd(0, 1, 1'(i % 2), "sat", 0);
      check_all("sat_end");
      check("sat_value", 32'(ld_total), 32'h0000FFFF);
      cmd(0, 1, 0, "sat_hold", 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/updown_datapath.md
Name: updown_datapath

Overview:
Datapath for the up/down counter. It executes the command signals from the counter controller (op, c_clr, c_ld) on a bounded count register. It returns the status signals z (decrement allowed) and m (increment allowed) that the controller uses to gate its next transition. It also provides a one-cycle update strobe, sticky overflow/underflow error flags and a saturating count of accepted steps.

Parameters:
WIDTH, 4, bit width of count register
MIN_VAL, 0, lower bound and clear value of count; must satisfy MIN_VAL <= MAX_VAL
MAX_VAL, 9, upper bound of count; must be < 2^WIDTH
STEP, 1, increment/decrement magnitude; must satisfy 1 <= STEP <= MAX_VAL-MIN_VAL

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op  input  1  step direction: 0 = increment, 1 = decrement; sampled only when c_ld=1
c_clr  input  1  clear command: count to MIN_VAL, clears flags and ld_total
c_ld  input  1  load command: apply one step in direction op
z  output  1  status: count >= MIN_VAL+STEP (decrement allowed)
m  output  1  status: count <= MAX_VAL-STEP (increment allowed)
count  output  WIDTH  current count value
upd  output  1  one-cycle pulse, high in the cycle a new count value is first visible
err_ovf  output  1  sticky: increment commanded while m=0
err_udf  output  1  sticky: decrement commanded while z=0
ld_total  output  16  number of accepted steps since clear/reset, saturating at 16'hFFFF

Behaviour:
- Clock and reset: reset is asynchronous, active-high; the clock is clk. While reset=1: count=MIN_VAL, upd=0, err_ovf=0, err_udf=0, ld_total=0. All other state updates occur on the rising edge of clk.
- Status outputs: z and m are combinational decodes of the count register only. There is no combinational path from op, c_clr or c_ld. The controller samples them in the same cycle.
- Arithmetic: computed in WIDTH+1 bits so that count+STEP and count-STEP cannot wrap silently.
- Command priority (evaluated per edge):
  1. c_clr=1: count<=MIN_VAL, err_ovf<=0, err_udf<=0, ld_total<=0, upd<=0. c_ld is ignored in that cycle.
  2. c_ld=1, op=0, m=1: count<=count+STEP, upd<=1, ld_total<=ld_total+1 (saturating).
  3. c_ld=1, op=0, m=0: count held, err_ovf<=1, upd<=0, ld_total held.
  4. c_ld=1, op=1, z=1: count<=count-STEP, upd<=1, ld_total+1 (saturating).
  5. c_ld=1, op=1, z=0: count held, err_udf<=1, upd<=0.
  6. Otherwise: all registers hold, upd<=0.
- Latency: one clock from command to the new count. upd is registered and aligned with the new count. z and m reflect the new count in the same cycle.
- Back-to-back c_ld pulses on consecutive cycles are each applied; no dead cycle is required.
- Error flags:
  - err_ovf and err_udf are set only by a rejected step.
  - They are cleared only by c_clr or reset.
  - Both can be set simultaneously over time.
- ld_total at 16'hFFFF stays at 16'hFFFF on further accepted steps.
- Reset mid-operation: count and all flags reach reset values immediately, without waiting for a clock edge. The first command honoured is on the first edge after reset deasserts.

Optional Feature:
Macro UPDOWN_WRAP_EN.
- Defined: modular counting.
  - Increment with count+STEP > MAX_VAL loads MIN_VAL.
  - Decrement with count < MIN_VAL+STEP loads MAX_VAL.
  - Both are accepted steps: upd pulses and ld_total increments.
  - z and m are tied to 1.
  - err_ovf and err_udf are tied to 0.
- Not defined: the saturating/rejecting behaviour above.

Test Plan:
1. Reset check (defaults: WIDTH=4, MIN=0, MAX=9, STEP=1). Assert reset -> count=0, z=0, m=1, upd=0, err_ovf=0, err_udf=0, ld_total=0.
2. Increment to the bound. Nine single-cycle c_ld with op=0 -> count steps 1..9, nine upd pulses each aligned with the new value, ld_total=9, and at count=9 m=0, z=1. A tenth c_ld with op=0 -> count=9, err_ovf=1, no upd, ld_total=9.
3. Decrement below the bound. From count=0, c_ld with op=1 -> count=0, err_udf=1, no upd. Then c_ld with op=0 -> count=1, err_udf still 1.
4. Clear priority. At count=5 with err_ovf=1, c_clr=1 and c_ld=1 (op=0) in the same cycle -> count=0, err_ovf=0, ld_total=0, upd=0.
5. Asynchronous reset. At count=7, raise reset midway between edges -> count=0 and ld_total=0 before the next rising edge. Release reset, then c_ld with op=0 -> count=1.
6. Wrap mode (UPDOWN_WRAP_EN defined):
   - At count=9, c_ld with op=0 -> count=0, upd=1, err_ovf=0.
   - Then c_ld with op=1 -> count=9.
   - z=1 and m=1 throughout.
